// File: rtl/posit_quire_accumulator_pkg.sv
// Width helpers and shared types for the posit dot-product quire accumulator.
// PositDef   : product field widths produced by the multiply-for-quire stage.
// QuireDef   : Kulisch quire sizing (integer and fraction sides).
// QuireAccDef: accumulator FSM state type and total quire width helper.

package PositDef;

  // Largest binary scale of a single posit: useed^(WIDTH-2) = 2^((WIDTH-2)*2^ES).
  function automatic int getMaxScale(input int width, input int es);
    return (width - 2) << es;
  endfunction

  // Signed product scale spans -2*maxScale .. +2*maxScale.
  function automatic int getExpProductBits(input int width, input int es);
    return $clog2(2 * getMaxScale(width, es) + 1) + 1;
  endfunction

  // Each significand is hidden bit plus WIDTH-ES-3 fraction bits; the product doubles that.
  function automatic int getFracProductBits(input int width, input int es);
    return 2 * (width - es - 2);
  endfunction

endpackage

package QuireDef;

  // Sign bit, one carry bit, the largest product scale, plus requested guard bits.
  function automatic int getNonFracBits(input int width, input int es, input int overflow,
                                        input int extra);
    return 2 * PositDef::getMaxScale(width, es) + 2 + overflow + extra;
  endfunction

  // Enough fraction bits to hold minpos*minpos exactly; guard bits only grow the integer side.
  function automatic int getFracBits(input int width, input int es, input int overflow);
    return 2 * PositDef::getMaxScale(width, es) + (overflow - overflow);
  endfunction

endpackage

package QuireAccDef;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } accStateT;

  function automatic int getAccBits(input int width, input int es, input int overflow);
    return QuireDef::getNonFracBits(width, es, overflow, 0) +
           QuireDef::getFracBits(width, es, overflow);
  endfunction

endpackage

// File: rtl/posit_quire_accumulator_align.sv
// QuireProductAlign: combinational stage-1 of the quire accumulator.
// Places abFrac x 2^abExp onto the quire grid (LSB weight 2^-ACC_FRAC), then
// applies the product sign and forces zero/NaR products to contribute nothing.

module QuireProductAlign #(
  parameter int EXP_BITS  = 6,
  parameter int FRAC_BITS = 10,
  parameter int ACC_FRAC  = 24,
  parameter int ACC_BITS  = 50
) (
  input  logic                       abIsInf,
  input  logic                       abIsZero,
  input  logic                       abSign,
  input  logic signed [EXP_BITS-1:0] abExp,
  input  logic [FRAC_BITS-1:0]       abFrac,
  output logic [ACC_BITS-1:0]        aligned
);

  // abFrac carries FRAC_BITS-2 fraction bits; the wide vector keeps them below the quire LSB
  // so that a right shift of the smallest scales is just a slice.
  localparam int WIDE_BITS  = ACC_BITS + FRAC_BITS - 2;
  localparam int SHIFT_BITS = $clog2(WIDE_BITS);

  logic [SHIFT_BITS-1:0] shiftAmt;
  logic [WIDE_BITS-1:0]  wide;
  logic [ACC_BITS-1:0]   mag;

  // Shift, slice to quire grid, negate and squash special products
  always_comb begin
    // NOTE: every output of this block is assigned before any branch, so no latch can form.
    shiftAmt = '0;
    wide     = '0;
    mag      = '0;
    aligned  = '0;
    // abExp >= -ACC_FRAC is guaranteed by quire sizing, so the shift is never negative.
    shiftAmt = SHIFT_BITS'(32'(abExp) + ACC_FRAC);
    wide     = WIDE_BITS'(abFrac) << shiftAmt;
    mag      = ACC_BITS'(wide >> (FRAC_BITS - 2));
    if (abIsZero || abIsInf) begin
      aligned = '0;
    end else if (abSign) begin
      aligned = -mag;
    end else begin
      aligned = mag;
    end
  end

endmodule

// File: rtl/posit_quire_accumulator.sv
// posit_quire_accumulator: streaming Kulisch-quire dot-product accumulator.
// Stage 1 aligns each exact product onto the quire grid, stage 2 sums it into acc.
// An inLast-terminated sequence is drained, then held on a valid/ready output
// until the quire-to-posit stage takes it.
// Optional feature: define POSIT_QUIRE_OVERFLOW_DETECT_EN to add sticky signed
// overflow detection on stage 2 (outOverflow); otherwise outOverflow is tied 0.

module posit_quire_accumulator
  import QuireAccDef::*;
#(
  parameter int  WIDTH        = 8,
  parameter int  ES           = 1,
  parameter int  OVERFLOW     = 0,
  localparam int EXP_BITS     = PositDef::getExpProductBits(WIDTH, ES),
  localparam int FRAC_BITS    = PositDef::getFracProductBits(WIDTH, ES),
  localparam int ACC_NON_FRAC = QuireDef::getNonFracBits(WIDTH, ES, OVERFLOW, 0),
  localparam int ACC_FRAC     = QuireDef::getFracBits(WIDTH, ES, OVERFLOW),
  localparam int ACC_BITS     = ACC_NON_FRAC + ACC_FRAC
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       inValid,
  output logic                       inReady,
  input  logic                       inLast,
  input  logic                       abIsInf,
  input  logic                       abIsZero,
  input  logic                       abSign,
  input  logic signed [EXP_BITS-1:0] abExp,
  input  logic [FRAC_BITS-1:0]       abFrac,
  output logic                       outValid,
  input  logic                       outReady,
  output logic                       outIsInf,
  output logic [ACC_BITS-1:0]        outQuire,
  output logic                       outOverflow
);

  accStateT            state;
  logic                accept;
  logic                holdDone;
  logic [ACC_BITS-1:0] aligned;
  logic                s1Valid;
  logic                s1Last;
  logic                s1Inf;
  logic [ACC_BITS-1:0] s1Aligned;
  logic [ACC_BITS-1:0] acc;
  logic [ACC_BITS-1:0] accSum;
  logic                infSticky;

  assign accept   = inValid && inReady;
  assign holdDone = (state == HOLD) && outReady;
  assign accSum   = acc + s1Aligned;

  QuireProductAlign #(
    .EXP_BITS (EXP_BITS),
    .FRAC_BITS(FRAC_BITS),
    .ACC_FRAC (ACC_FRAC),
    .ACC_BITS (ACC_BITS)
  ) u_align (
    .abIsInf (abIsInf),
    .abIsZero(abIsZero),
    .abSign  (abSign),
    .abExp   (abExp),
    .abFrac  (abFrac),
    .aligned (aligned)
  );

  // Stage 1: register the aligned term with its valid, last and inf flags
  always_ff @(posedge clock) begin
    // NOTE: registers use <= so every flop samples the values that existed before the edge.
    if (reset) begin
      s1Valid <= 1'b0;
    end else begin
      s1Valid <= accept;
    end
    // NOTE: payload flops are qualified by s1Valid, so only the valid bit needs a reset.
    s1Last    <= inLast;
    s1Inf     <= abIsInf;
    s1Aligned <= aligned;
  end

  // Stage 2 and sequencing: accumulate terms, drain the last one, hold the result
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ACCUM;
      inReady   <= 1'b1;
      outValid  <= 1'b0;
      acc       <= '0;
      infSticky <= 1'b0;
    end else begin
      if (s1Valid) begin
        acc       <= accSum;
        infSticky <= infSticky | s1Inf;
      end
      case (state)
        ACCUM: begin
          if (accept && inLast) begin
            state   <= DRAIN;
            inReady <= 1'b0;
          end
        end
        DRAIN: begin
          // The last term is summing on this edge, so acc is final when outValid rises.
          if (s1Valid && s1Last) begin
            state    <= HOLD;
            outValid <= 1'b1;
          end
        end
        HOLD: begin
          // No term can be in stage 1 here, so clearing acc cannot collide with an add.
          if (outReady) begin
            state     <= ACCUM;
            inReady   <= 1'b1;
            outValid  <= 1'b0;
            acc       <= '0;
            infSticky <= 1'b0;
          end
        end
        default: begin
          state    <= ACCUM;
          inReady  <= 1'b1;
          outValid <= 1'b0;
        end
      endcase
    end
  end

  assign outQuire = acc;
  assign outIsInf = infSticky;

`ifdef POSIT_QUIRE_OVERFLOW_DETECT_EN
  logic accOvf;
  logic ovfSticky;

  // Two's-complement overflow: operands agree in sign but the sum does not.
  assign accOvf = (acc[ACC_BITS-1] == s1Aligned[ACC_BITS-1]) &&
                  (accSum[ACC_BITS-1] != acc[ACC_BITS-1]);

  // Sticky overflow flag, cleared together with acc when the result is taken
  always_ff @(posedge clock) begin
    if (reset || holdDone) begin
      ovfSticky <= 1'b0;
    end else if (s1Valid && accOvf) begin
      ovfSticky <= 1'b1;
    end
  end

  assign outOverflow = ovfSticky;
`else
  assign outOverflow = 1'b0;
`endif

endmodule
